ram_fill_writer: RTL and testbench
==================================

Name: ram_fill_writer

Overview:
- Write-side counterpart to the single-port on-chip ROM/RAM IP read path.
- Accepts a valid/ready byte stream and writes it to sequential RAM addresses starting at a programmable base, wrapping at the top of the address space.
- After the last write it reads the region back through the IP's registered read port and compares a running checksum, then reports done and pass/fail.
- Sits between a data source (UART/loader) and the altsyncram-style memory IP.

Parameters:
- ADDR_W, 8, RAM address width; depth is 2^ADDR_W.
- DATA_W, 8, RAM word width.
- SUM_W, 16, checksum accumulator width; sums wrap modulo 2^SUM_W.
- RD_LAT, 2, cycles from ram_addr driven (verify phase) to ram_q sampled by this block.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address, latched on accepted start.
- length  in  ADDR_W+1  word count, 0..2^ADDR_W, latched on accepted start.
- s_valid  in  1  stream data valid.
- s_data  in  DATA_W  stream data.
- s_ready  out  1  block accepts s_data this cycle.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_data  out  DATA_W  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- ram_q  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- verify_ok  out  1  readback checksum matched; valid from done until the next accepted start.
- checksum  out  SUM_W  sum of written words; valid from done until the next accepted start.

Behaviour:
- Reset (async, any time): state IDLE; all outputs 0; counters and sums 0. Words already written stay in RAM. No done pulse is generated.
- States: IDLE, WRITE, DRAIN, VERIFY, FINISH.
- IDLE:
  - start=1, length=0: go to FINISH directly; checksum=0, verify_ok=1; no RAM access.
  - start=1, length>0: latch base_addr and length; clear cnt, wsum, rsum, verify_ok, checksum; go to WRITE.
- WRITE:
  - s_ready = (state==WRITE), combinational from state.
  - Beat accepted when s_valid & s_ready. On the next cycle: ram_wren=1, ram_addr=base+cnt (mod 2^ADDR_W), ram_data=s_data; wsum += s_data; cnt++.
  - ram_wren is 0 in every cycle without an accepted beat; stalls insert no writes.
  - On the accept where cnt==length-1, go to DRAIN; s_ready falls the following cycle.
- DRAIN: exactly one cycle. The last write commits here (ram_wren=1). Then go to VERIFY with cnt=0.
- VERIFY:
  - ram_wren=0; ram_addr=base+cnt, one new address per cycle for length cycles.
  - A RD_LAT-deep valid shift register tags returning data; rsum += ram_q for each tagged cycle.
  - When all length words have returned, go to FINISH.
- FINISH: one cycle. done=1; checksum=wsum; verify_ok=(rsum==wsum); then go to IDLE.
- Address wrap: base+cnt is truncated to ADDR_W bits, so base=250, length=10 gives addresses 250..255, 0..3.
- Start while busy is ignored: no latch, no effect.
- Simultaneous start and reset: reset wins.
- Best-case total latency, start to done: 1 + length + 1 + length + RD_LAT + 1 cycles (length>0, s_valid held high).

Test Plan:
- Full sweep: base=0, length=256, s_data=0..255 with s_valid high every cycle -> 256 consecutive ram_wren pulses, addrs 0..255. checksum=32640, verify_ok=1, exactly one done pulse 1+256+1+256+2+1=517 cycles after start.
- Bubbles: base=16, length=8, s_valid toggling 1/0 -> ram_wren only on accepted beats, addrs 16..23 in order. checksum equals the data sum; no extra writes.
- Wrap: base=250, length=10, data 1..10 -> addrs 250..255,0..3. checksum=55, verify_ok=1.
- Zero length: start with length=0 -> done the cycle after the next, no ram_wren, s_ready never high, checksum=0, verify_ok=1.
- Corrupt readback: bench RAM model flips bit 0 of ram_q at addr 5 -> verify_ok=0; checksum still equals the written sum.
- Reset/ignore: reset after 5 beats of length=20 -> all outputs 0, state IDLE, no done. A second start pulsed mid-WRITE -> ignored; the run ends with the first length.

Source files
------------

// File: rtl/ram_fill_writer.sv
// Streams bytes into sequential RAM addresses from a programmable base, then reads
// the region back through the registered read port and compares running checksums.
module ram_fill_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              verify_ok,
  output logic [SUM_W-1:0]  checksum
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_VERIFY = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   rcnt;
  logic [ADDR_W:0]   len_m1;
  logic [SUM_W-1:0]  wsum;
  logic [SUM_W-1:0]  rsum;
  logic [RD_LAT-1:0] vsr;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept;
  logic              issue;
  logic              ret;

  // Stream handshake: a beat transfers on a rising edge where s_valid and s_ready
  // are both high; s_ready depends only on state, never on s_valid.
  assign s_ready  = (state == ST_WRITE);
  assign busy     = (state != ST_IDLE);
  assign accept   = s_valid & s_ready;
  assign len_m1   = len_r - CNT_ONE;
  assign cur_addr = base_r + cnt[ADDR_W-1:0];
  assign issue    = (state == ST_VERIFY) && (cnt != len_r);
  assign ret      = vsr[RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      base_r    <= '0;
      len_r     <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      wsum      <= '0;
      rsum      <= '0;
      vsr       <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_wren  <= 1'b0;
      done      <= 1'b0;
      verify_ok <= 1'b0;
      checksum  <= '0;
    end else begin
      ram_wren <= 1'b0;
      done     <= 1'b0;
      // Each set bit marks a read whose data arrives RD_LAT cycles after issue.
      vsr      <= (vsr << 1) | RD_LAT'(issue);
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_r    <= base_addr;
            len_r     <= length;
            cnt       <= '0;
            rcnt      <= '0;
            wsum      <= '0;
            rsum      <= '0;
            checksum  <= '0;
            verify_ok <= 1'b0;
            state     <= (length == '0) ? ST_FINISH : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (accept) begin
            ram_wren <= 1'b1;
            ram_addr <= cur_addr;
            ram_data <= s_data;
            wsum     <= wsum + SUM_W'(s_data);
            cnt      <= cnt + CNT_ONE;
            if (cnt == len_m1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          cnt   <= '0;
          state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (issue) begin
            ram_addr <= cur_addr;
            cnt      <= cnt + CNT_ONE;
          end
          if (ret) begin
            rsum <= rsum + SUM_W'(ram_q);
            rcnt <= rcnt + CNT_ONE;
            if (rcnt == len_m1) state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done      <= 1'b1;
          checksum  <= wsum;
          verify_ok <= (rsum == wsum);
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fill_writer.sv
// Directed bench for ram_fill_writer with a one-register-stage RAM model and a
// write scoreboard that checks every ram_wren pulse against the expected stream.
module tb_ram_fill_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  length = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic [7:0]  ram_q;
  logic        busy;
  logic        done;
  logic        verify_ok;
  logic [15:0] checksum;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wren_cnt = 0;
  int rdy_cnt = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  data_tab[256];
  logic [7:0]  mem[256];
  bit          corrupt = 1'b0;

  ram_fill_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .done(done), .verify_ok(verify_ok), .checksum(checksum)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address registered at the edge, so data is ready for the following edge
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr] ^ ((corrupt && ram_addr == 8'd5) ? 8'h01 : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard on the write port
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wren) begin
        wren_cnt++;
        if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr_data", {16'd0, ram_addr, ram_data}, {16'd0, exp_q.pop_front()});
      end
      if (done) done_cnt++;
      if (s_ready) rdy_cnt++;
    end
  end

  // driver: start a run, feed len beats, return start-to-done latency (-1 on timeout)
  task automatic do_run(input logic [7:0] b, input int len, input bit bubble,
                        input int poke, input int max_cyc, output int lat);
    int idx = 0;
    int cs;
    int n = 0;
    bit poked = 1'b0;
    bit ph = 1'b1;
    @(negedge clk);
    base_addr = b;
    length = 9'(len);
    start = 1'b1;
    s_valid = 1'b0;
    cs = cyc;
    lat = -1;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) begin
        lat = cyc - cs;
        break;
      end
      if (poke >= 0 && idx == poke && !poked) begin
        start = 1'b1;
        base_addr = 8'd0;
        length = 9'd9;
        poked = 1'b1;
      end
      if (idx < len) begin
        s_valid = bubble ? ph : 1'b1;
        ph = ~ph;
        s_data = data_tab[idx];
        if (s_valid && s_ready) begin
          exp_q.push_back({b + 8'(idx), data_tab[idx]});
          idx++;
        end
      end else begin
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic post_checks(input string tag, input int len, input int d0, input int w0,
                             input logic [15:0] sum, input logic ok);
    repeat (3) @(negedge clk);
    check({tag, "_checksum"}, {16'd0, checksum}, {16'd0, sum});
    check({tag, "_verify_ok"}, {31'd0, verify_ok}, {31'd0, ok});
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_writes"}, wren_cnt - w0, len);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, d0, w0, r0, idx;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_q = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_s_ready", {31'd0, s_ready}, 0);
    check("rst_wren", {31'd0, ram_wren}, 0);
    check("rst_addr_data", {16'd0, ram_addr, ram_data}, 0);
    check("rst_done_ok", {30'd0, done, verify_ok}, 0);
    check("rst_checksum", {16'd0, checksum}, 0);
    rst = 1'b0;

    // full sweep
    for (int i = 0; i < 256; i++) data_tab[i] = 8'(i);
    d0 = done_cnt; w0 = wren_cnt;
    do_run(8'd0, 256, 1'b0, -1, 600, lat);
    check("sweep_latency", lat, 517);
    post_checks("sweep", 256, d0, w0, 16'd32640, 1'b1);

    // bubbles
    data_tab[0] = 8'hA0; data_tab[1] = 8'hB1; data_tab[2] = 8'hC2; data_tab[3] = 8'hD3;
    data_tab[4] = 8'hE4; data_tab[5] = 8'hF5; data_tab[6] = 8'h06; data_tab[7] = 8'h17;
    d0 = done_cnt; w0 = wren_cnt;
    do_run(8'd16, 8, 1'b1, -1, 80, lat);
    check("bubble_finished", {31'd0, lat > 0}, 1);
    post_checks("bubble", 8, d0, w0, 16'd1244, 1'b1);

    // wrap at top of address space
    for (int i = 0; i < 10; i++) data_tab[i] = 8'(i + 1);
    d0 = done_cnt; w0 = wren_cnt;
    do_run(8'd250, 10, 1'b0, -1, 60, lat);
    check("wrap_latency", lat, 25);
    post_checks("wrap", 10, d0, w0, 16'd55, 1'b1);

    // corrupted readback at address 5
    for (int i = 0; i < 8; i++) data_tab[i] = 8'(i + 10);
    corrupt = 1'b1;
    d0 = done_cnt; w0 = wren_cnt;
    do_run(8'd0, 8, 1'b0, -1, 60, lat);
    check("corrupt_latency", lat, 21);
    post_checks("corrupt", 8, d0, w0, 16'd108, 1'b0);
    corrupt = 1'b0;

    // zero length
    d0 = done_cnt; w0 = wren_cnt; r0 = rdy_cnt;
    do_run(8'd77, 0, 1'b0, -1, 20, lat);
    check("zero_latency", lat, 2);
    check("zero_no_ready", rdy_cnt - r0, 0);
    post_checks("zero", 0, d0, w0, 16'd0, 1'b1);

    // start pulsed mid-WRITE is ignored
    for (int i = 0; i < 4; i++) data_tab[i] = 8'(i + 1);
    d0 = done_cnt; w0 = wren_cnt;
    do_run(8'd100, 4, 1'b0, 2, 40, lat);
    check("ignore_latency", lat, 13);
    post_checks("ignore", 4, d0, w0, 16'd10, 1'b1);

    // reset after 5 beats of a 20-beat run
    for (int i = 0; i < 20; i++) data_tab[i] = 8'(i + 50);
    d0 = done_cnt; w0 = wren_cnt;
    @(negedge clk);
    base_addr = 8'd40; length = 9'd20; start = 1'b1; s_valid = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && idx < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      s_valid = 1'b1;
      s_data = data_tab[idx];
      if (s_ready) begin
        exp_q.push_back({8'd40 + 8'(idx), data_tab[idx]});
        idx++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_outputs", {ram_addr, ram_data, 7'd0, ram_wren, 7'd0, s_ready}, 0);
    check("midrst_status", {15'd0, done, checksum}, 0);
    check("midrst_state", {29'd0, dut.state}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_writes", wren_cnt - w0, 5);
    check("midrst_sb_empty", exp_q.size(), 0);
    check("midrst_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
